// File: rtl/uart_rx_8n1.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_8n1
//
// Receive-only 8N1 UART. The serial line is oversampled at CLKS_PER_BIT clocks
// per bit. Every start bit resynchronises the bit timing. Each byte is then
// sampled at the centre of its data bits, LSB first.
//
// Handshake: there is no back-pressure. rxdone is a one-cycle strobe meaning
// "rxbyte has just been updated with a correctly framed byte". The consumer
// must take rxbyte on that cycle, or at least before the next rxdone.
// framing_err is a one-cycle strobe for a frame whose stop bit was sampled low.
// That byte is dropped and rxbyte keeps its previous value. The two strobes
// are never high together.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   rx           serial input, asynchronous to clk, idles high
//   rxbyte[7:0]  last correctly framed byte (held until the next good frame)
//   rxdone       one-cycle pulse: rxbyte just updated
//   framing_err  one-cycle pulse: stop bit low, byte discarded
//   busy         high whenever the receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rxbyte,
  output logic       rxdone,
  output logic       framing_err,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  // Two-flop synchroniser. Both flops reset to the idle level of the line,
  // so reset itself never looks like a start bit.
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic rx_s;

  state_t          state_q,  state_d;
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic [2:0]      bitidx_q, bitidx_d;
  logic [7:0]      shreg_q,  shreg_d;
  logic [7:0]      rxbyte_q, rxbyte_d;
  logic            rxdone_q, rxdone_d;
  logic            ferr_q,   ferr_d;

  assign rx_s = sync2_q;

  always_comb begin
    sync1_d  = rx;
    sync2_d  = sync1_q;

    state_d  = state_q;
    cnt_d    = cnt_q;
    bitidx_d = bitidx_q;
    shreg_d  = shreg_q;
    rxbyte_d = rxbyte_q;
    rxdone_d = 1'b0;
    ferr_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d    = '0;
        bitidx_d = 3'd0;
        if (!rx_s) begin
          state_d = S_START;
        end
      end

      // Wait half a bit, then re-check the line. A pulse shorter than that is
      // treated as a glitch and dropped without any strobe.
      S_START: begin
        if (cnt_q == CNT_HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // The counter is now phased to mid-bit. Each full period lands on the
      // centre of the next data bit.
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          shreg_d  = {rx_s, shreg_q[7:1]};
          bitidx_d = bitidx_q + 3'd1;
          if (bitidx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // The FSM leaves at mid-stop bit. This leaves half a bit of slack to
      // catch a start bit that follows the stop bit directly.
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            rxbyte_d = shreg_q;
            rxdone_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // A line held low (break) must not be taken as a stream of start bits.
      // Stay here until the line returns high.
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        bitidx_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitidx_q <= 3'd0;
      shreg_q  <= 8'h00;
      rxbyte_q <= 8'h00;
      rxdone_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitidx_q <= bitidx_d;
      shreg_q  <= shreg_d;
      rxbyte_q <= rxbyte_d;
      rxdone_q <= rxdone_d;
      ferr_q   <= ferr_d;
    end
  end

  assign rxbyte      = rxbyte_q;
  assign rxdone      = rxdone_q;
  assign framing_err = ferr_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx_8n1
//
// Serial frames are built bit by bit from the byte value and a baud scale.
// The scale is given in hundredths of a clock per bit, so off-nominal baud
// rates stay in integer arithmetic. Each frame places its expected outcome in
// exp_q: bit 8 is set for a framing error, and bits 7:0 hold the byte. A
// monitor pops one entry for each strobe from the DUT.
// -----------------------------------------------------------------------------
module tb_uart_rx_8n1;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB;  // E0 -> stop-sample edge

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rxbyte;
  logic       rxdone;
  logic       framing_err;
  logic       busy;

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rxbyte      (rxbyte),
    .rxdone      (rxdone),
    .framing_err (framing_err),
    .busy        (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         done_cyc_q[$];
  int         n_done = 0;
  int         n_ferr = 0;
  logic       prev_pulse = 1'b0;
  int         frame_start = 0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      prev_pulse = 1'b0;
    end else begin
      if (rxdone || framing_err) begin
        check("pulse_excl", int'(rxdone & framing_err), 0);
        check("pulse_gap", int'(prev_pulse), 0);
        if (exp_q.size() == 0) begin
          check("spurious_pulse", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", int'(framing_err), int'(e[8]));
          if (rxdone) begin
            check("rxbyte", int'(rxbyte), int'(e[7:0]));
            last_good = e[7:0];
            n_done++;
            done_cyc_q.push_back(cyc);
          end else begin
            check("rxbyte_hold", int'(rxbyte), int'(last_good));
            n_ferr++;
          end
        end
      end
      prev_pulse = rxdone | framing_err;
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // Drive one frame. per100 is the bit period in hundredths of a clock.
  // If abort_at >= 0, reset is pulsed asynchronously on that cycle.
  task automatic send_frame(input logic [7:0] b, input int per100,
                            input logic stop_v, input int abort_at);
    int   bi;
    logic v;
    if (abort_at < 0) exp_q.push_back({~stop_v, b});
    for (int c = 0; ; c++) begin
      bi = (c * 100) / per100;
      if (bi >= 10) break;
      if (bi == 0)      v = 1'b0;
      else if (bi == 9) v = stop_v;
      else              v = b[bi-1];
      @(negedge clk);
      rx = v;
      if (c == 0) frame_start = cyc;
      if (c == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("rst_rxbyte", int'(rxbyte), 0);
        check("rst_rxdone", int'(rxdone), 0);
        check("rst_ferr",   int'(framing_err), 0);
        check("rst_busy",   int'(busy), 0);
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        return;
      end
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, exp_q.size(), 0);
    idle(4);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, nd, nf, busy_cnt, nbad, pct;
    logic [7:0] rb;
    logic       bad;

    repeat (3) @(negedge clk);
    check("reset_rxbyte", int'(rxbyte), 0);
    check("reset_rxdone", int'(rxdone), 0);
    check("reset_ferr",   int'(framing_err), 0);
    check("reset_busy",   int'(busy), 0);
    rst = 1'b0;
    idle(20);

    // Single frame at nominal baud, strobe timing against E154.
    d0 = done_cyc_q.size();
    send_frame(8'hA5, CPB * 100, 1'b1, -1);
    idle(10);
    drain("drain_a5");
    check("a5_count", done_cyc_q.size() - d0, 1);
    if (done_cyc_q.size() > d0)
      check("a5_latency", done_cyc_q[d0] - frame_start, LAT + 1);
    check("a5_rxbyte", int'(rxbyte), 'hA5);
    check("a5_no_ferr", n_ferr, 0);

    // Back-to-back frames with no idle gap.
    d0 = done_cyc_q.size();
    send_frame(8'h00, CPB * 100, 1'b1, -1);
    send_frame(8'hFF, CPB * 100, 1'b1, -1);
    send_frame(8'h3C, CPB * 100, 1'b1, -1);
    idle(10);
    drain("drain_b2b");
    check("b2b_count", done_cyc_q.size() - d0, 3);
    if (done_cyc_q.size() >= d0 + 3) begin
      check("b2b_gap1", done_cyc_q[d0+1] - done_cyc_q[d0], 10 * CPB);
      check("b2b_gap2", done_cyc_q[d0+2] - done_cyc_q[d0+1], 10 * CPB);
    end
    check("b2b_no_ferr", n_ferr, 0);

    // 3-cycle low glitch on an idle line.
    nd = n_done; nf = n_ferr; busy_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      rx = 1'b0;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rx = 1'b1;
      if (busy) busy_cnt++;
    end
    check("glitch_busy_seen", int'(busy_cnt > 0), 1);
    check("glitch_busy_le11", int'(busy_cnt <= 11), 1);
    check("glitch_busy_end", int'(busy), 0);
    check("glitch_no_done", n_done - nd, 0);
    check("glitch_no_ferr", n_ferr - nf, 0);

    // Bad stop bit, then a 40-bit break, then a good frame.
    nd = n_done; nf = n_ferr;
    send_frame(8'h55, CPB * 100, 1'b0, -1);
    repeat (40 * CPB) @(negedge clk);   // rx stays low
    check("break_rxbyte_hold", int'(rxbyte), 'h3C);
    idle(3 * CPB);
    send_frame(8'h81, CPB * 100, 1'b1, -1);
    idle(10);
    drain("drain_break");
    check("break_ferr_once", n_ferr - nf, 1);
    check("break_done_once", n_done - nd, 1);
    check("break_rxbyte", int'(rxbyte), 'h81);

    // Baud mismatch of +/-4 %.
    send_frame(8'h96, CPB * 104, 1'b1, -1);
    idle(2 * CPB);
    drain("drain_slow");
    check("slow_rxbyte", int'(rxbyte), 'h96);
    send_frame(8'h96, CPB * 96, 1'b1, -1);
    idle(2 * CPB);
    drain("drain_fast");
    check("fast_rxbyte", int'(rxbyte), 'h96);

    // Asynchronous reset during data bit 4, then a clean frame.
    nd = n_done; nf = n_ferr;
    send_frame(8'hC3, CPB * 100, 1'b1, 5 * CPB + HALF);
    idle(2 * CPB);
    check("abort_no_pulse", (n_done - nd) + (n_ferr - nf), 0);
    send_frame(8'h7E, CPB * 100, 1'b1, -1);
    idle(10);
    drain("drain_7e");
    check("post_rst_rxbyte", int'(rxbyte), 'h7E);

    // Randomised frames: byte, baud within +/-3 %, gaps and bad stop bits.
    nf = n_ferr; nbad = 0;
    for (int k = 0; k < 24; k++) begin
      rb  = 8'($urandom_range(0, 255));
      pct = $urandom_range(97, 103);
      bad = ($urandom_range(0, 7) == 0);
      if (bad) nbad++;
      send_frame(rb, CPB * pct, ~bad, -1);
      if (bad) idle(2 * CPB + $urandom_range(0, CPB));
      else     idle($urandom_range(0, 2 * CPB));
    end
    idle(10);
    drain("drain_random");
    check("random_ferr_count", n_ferr - nf, nbad);

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
